// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - default data width / register count
//   - RISC-V ABI register indices, used by decode and benches
//   - addr_width(): address width for a given register count
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;
    localparam int REG_TP   = 4;
    localparam int REG_T0   = 5;
    localparam int REG_T1   = 6;
    localparam int REG_T2   = 7;
    localparam int REG_S0   = 8;
    localparam int REG_S1   = 9;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;
    localparam int REG_A2   = 12;
    localparam int REG_A3   = 13;
    localparam int REG_A4   = 14;
    localparam int REG_A5   = 15;
    localparam int REG_A6   = 16;
    localparam int REG_A7   = 17;
    localparam int REG_S2   = 18;
    localparam int REG_S3   = 19;
    localparam int REG_S4   = 20;
    localparam int REG_S5   = 21;
    localparam int REG_S6   = 22;
    localparam int REG_S7   = 23;
    localparam int REG_S8   = 24;
    localparam int REG_S9   = 25;
    localparam int REG_S10  = 26;
    localparam int REG_S11  = 27;
    localparam int REG_T3   = 28;
    localparam int REG_T4   = 29;
    localparam int REG_T5   = 30;
    localparam int REG_T6   = 31;

    // Address width; never below 1 so port slices stay legal.
    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/register_file_rdport.sv
// One registered read port of the multi-port register file.
// Ports:
//   clk, rst_n   clock, async active-low clear of rdata
//   re, ra       read enable and address
//   regs         current storage contents (pre-edge values)
//   we, wa, wdata all write ports, used for same-edge bypass
//   rdata        registered read result, held while re=0
module register_file_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = addr_width(NREGS_DEF),
    parameter int NW       = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          re,
    input  logic [AW-1:0]                 ra,
    input  logic [NREGS-1:0][XLEN-1:0]    regs,
    input  logic [NW-1:0]                 we,
    input  logic [NW-1:0][AW-1:0]         wa,
    input  logic [NW-1:0][XLEN-1:0]       wdata,
    output logic [XLEN-1:0]               rdata
);

    logic            readable;
    logic [XLEN-1:0] rd_next;

    // Zero register and out-of-range addresses both read as 0.
    assign readable = !((ZERO_REG != 0) && (ra == '0)) && (int'(ra) < NREGS);

    always_comb begin
        rd_next = '0;
        if (readable) begin
            rd_next = regs[ra];
            // Ascending scan: the highest matching write port is applied last,
            // matching the storage write priority.
            for (int j = 0; j < NW; j++) begin
                if ((BYPASS != 0) && we[j] && (wa[j] == ra))
                    rd_next = wdata[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= rd_next;
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file.
// Ports:
//   clk, rst_n  clock, async active-low clear of storage and rdata
//   re, ra      NR read enables / addresses (port i: ra[i*AW +: AW])
//   rdata       NR registered read results (port i: rdata[i*XLEN +: XLEN])
//   we, wa      NW write enables / addresses (port j: wa[j*AW +: AW])
//   wdata       NW write data (port j: wdata[j*XLEN +: XLEN])
// Highest-index write port wins on an address conflict.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NR       = 2,
    parameter  int NW       = 1,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = addr_width(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NR-1:0]        re,
    input  logic [NR*AW-1:0]     ra,
    output logic [NR*XLEN-1:0]   rdata,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     wa,
    input  logic [NW*XLEN-1:0]   wdata
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NW-1:0][AW-1:0]      wa_v;
    logic [NW-1:0][XLEN-1:0]    wd_v;
    logic [NR-1:0][AW-1:0]      ra_v;
    logic [NR-1:0][XLEN-1:0]    rd_v;

    assign wa_v  = wa;
    assign wd_v  = wdata;
    assign ra_v  = ra;
    assign rdata = rd_v;

    // Out-of-range write addresses match no register and are dropped. With
    // ZERO_REG, entry 0 is never written and stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (!((ZERO_REG != 0) && (r == 0))) begin
                    for (int j = 0; j < NW; j++) begin
                        if (we[j] && (wa_v[j] == AW'(r)))
                            regs[r] <= wd_v[j];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        register_file_rdport #(
            .XLEN    (XLEN),
            .NREGS   (NREGS),
            .AW      (AW),
            .NW      (NW),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .clk  (clk),
            .rst_n(rst_n),
            .re   (re[i]),
            .ra   (ra_v[i]),
            .regs (regs),
            .we   (we),
            .wa   (wa_v),
            .wdata(wd_v),
            .rdata(rd_v[i])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp. Three instances share stimulus:
//   dut0: defaults (NREGS=32, NW=1, ZERO_REG=1, BYPASS=1)
//   dut1: NREGS=24, NW=2, ZERO_REG=0, BYPASS=0
//   dut2: NREGS=32, NW=2, ZERO_REG=1, BYPASS=1
// A per-instance array model tracks every cycle; directed tables and
// sequences add hand-computed expectations.
module tb_register_file_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wdata;
    logic [63:0] rdata0, rdata1, rdata2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem    [3][32];
    logic [31:0] exp_rd [3][2];

    always #5 clk = ~clk;

    register_file_mp #(.NW(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rdata(rdata0),
        .we(we[0:0]), .wa(wa[4:0]), .wdata(wdata[31:0]));

    register_file_mp #(.NREGS(24), .NW(2), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rdata(rdata1),
        .we(we), .wa(wa), .wdata(wdata));

    register_file_mp #(.NW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rdata(rdata2),
        .we(we), .wa(wa), .wdata(wdata));

    function automatic logic [31:0] get_rd(input int d, input int i);
        logic [63:0] v;
        v = (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata2;
        return v[i*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 32; r++) mem[d][r] = '0;
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
        end
    endtask

    // Behaviour of one rising edge: reads see pre-edge contents (or the
    // highest-index same-edge write when bypassing), then writes land in
    // port order so the highest index wins.
    task automatic model_edge(input int d);
        int nregs, nw;
        bit zr, byp;
        int a;
        logic [31:0] v;
        nregs = (d == 1) ? 24 : 32;
        nw    = (d == 0) ? 1 : 2;
        zr    = (d != 1);
        byp   = (d != 1);
        for (int i = 0; i < 2; i++) begin
            if (re[i]) begin
                a = int'(ra[i*5 +: 5]);
                v = '0;
                if (!(zr && a == 0) && a < nregs) begin
                    v = mem[d][a];
                    if (byp) begin
                        for (int j = nw - 1; j >= 0; j--) begin
                            if (we[j] && int'(wa[j*5 +: 5]) == a) begin
                                v = wdata[j*32 +: 32];
                                break;
                            end
                        end
                    end
                end
                exp_rd[d][i] = v;
            end
        end
        for (int j = 0; j < nw; j++) begin
            a = int'(wa[j*5 +: 5]);
            if (we[j] && a < nregs && !(zr && a == 0))
                mem[d][a] = wdata[j*32 +: 32];
        end
    endtask

    task automatic cmp_all(input string tag);
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 2; i++)
                chk($sformatf("%s_d%0d_p%0d", tag, d, i), get_rd(d, i), exp_rd[d][i]);
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst_n) for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        cmp_all(tag);
    endtask

    task automatic idle();
        we = '0; re = '0; wa = '0; ra = '0; wdata = '0;
    endtask

    typedef struct {
        string       name;
        bit          we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        bit          re0;
        logic [4:0]  ra0;
        logic [31:0] exp0;   // dut0/dut2 port 0
        logic [31:0] exp1;   // dut1 port 0
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"wr_x10",    1'b1, 5'd10, 32'h12345678, 1'b0, 5'd0,  32'h0,        32'h0};
        tbl[1] = '{"rd_x10",    1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h12345678, 32'h12345678};
        tbl[2] = '{"hold",      1'b1, 5'd10, 32'h1,        1'b0, 5'd10, 32'h12345678, 32'h12345678};
        tbl[3] = '{"rd_new",    1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1,        32'h1};
        tbl[4] = '{"bypass",    1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  32'hA5A5A5A5, 32'h0};
        tbl[5] = '{"wr_x0",     1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'h0,        32'h0};
        tbl[6] = '{"rd_x0",     1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,        32'hFFFFFFFF};
        tbl[7] = '{"rd_x7",     1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};

        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        rst_n = 1'b1;

        // Directed table (port 1 idle).
        foreach (tbl[k]) begin
            idle();
            we[0] = tbl[k].we0; wa[4:0] = tbl[k].wa0; wdata[31:0] = tbl[k].wd0;
            re[0] = tbl[k].re0; ra[4:0] = tbl[k].ra0;
            cyc(tbl[k].name);
            chk({tbl[k].name, "_d0"}, rdata0[31:0], tbl[k].exp0);
            chk({tbl[k].name, "_d1"}, rdata1[31:0], tbl[k].exp1);
        end

        // Write conflict on x3, with a same-edge read on port 0.
        idle();
        we = 2'b11; wa = {5'd3, 5'd3}; wdata = {32'h222, 32'h111};
        re = 2'b01; ra[4:0] = 5'd3;
        cyc("conflict");
        chk("conflict_byp_d2", rdata2[31:0], 32'h222);
        chk("conflict_nobyp_d1", rdata1[31:0], 32'h0);
        idle();
        re = 2'b11; ra = {5'd3, 5'd3};
        cyc("conflict_rd");
        chk("conflict_d2_p1", rdata2[63:32], 32'h222);
        chk("conflict_d1_p0", rdata1[31:0], 32'h222);
        chk("conflict_d0_p0", rdata0[31:0], 32'h111);

        // Out-of-range address 30 on the 24-entry instance.
        idle();
        we = 2'b01; wa[4:0] = 5'd30; wdata[31:0] = 32'h55;
        cyc("oor_wr");
        idle();
        re = 2'b01; ra[4:0] = 5'd30;
        cyc("oor_rd");
        chk("oor_d1", rdata1[31:0], 32'h0);
        chk("oor_d0", rdata0[31:0], 32'h55);
        for (int r = 0; r < 24; r += 2) begin
            idle();
            re = 2'b11; ra = {5'(r + 1), 5'(r)};
            cyc("oor_sweep");
        end

        // Asynchronous reset mid-cycle.
        idle();
        we = 2'b01; wa[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        cyc("rst_wr");
        idle();
        re = 2'b01; ra[4:0] = 5'd5;
        cyc("rst_rd");
        chk("rst_pre", rdata0[31:0], 32'hDEADBEEF);
        we = 2'b11; wa = {5'd5, 5'd5}; wdata = {32'h77, 32'h66};
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_d0", rdata0[31:0], 32'h0);
        chk("rst_async_d1", rdata1[31:0], 32'h0);
        cmp_all("rst_async");
        cyc("rst_held");
        rst_n = 1'b1;
        idle();
        re = 2'b01; ra[4:0] = 5'd5;
        cyc("rst_after");
        chk("rst_after_d0", rdata0[31:0], 32'h0);
        chk("rst_after_d2", rdata2[31:0], 32'h0);

        // Randomized traffic, biased towards read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            we    = 2'($urandom_range(0, 3));
            wa    = 10'($urandom);
            wdata = {$urandom, $urandom};
            re    = 2'($urandom_range(0, 3));
            ra    = 10'($urandom);
            if ($urandom_range(0, 1) == 1) ra[4:0] = wa[4:0];
            if ($urandom_range(0, 1) == 1) ra[9:5] = wa[9:5];
            if ($urandom_range(0, 3) == 0) wa[9:5] = wa[4:0];
            if ($urandom_range(0, 7) == 0) ra[4:0] = 5'd0;
            cyc("rand");
        end

        // Final sweep of every address.
        for (int r = 0; r < 32; r += 2) begin
            idle();
            re = 2'b11; ra = {5'(r + 1), 5'(r)};
            cyc("final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read CPU register file.
- Configurable data width, register count, and number of read and write ports.
- Adds registered read ports with read-enable, optional write-to-read bypass, deterministic multi-writer priority, and asynchronous clearing of all registers on reset.
- Sits between decode (read addresses) and writeback (write ports) in the core; the multi-write-port configurations serve the planned dual-issue pipeline.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (>=2); AW = clog2(NREGS) is a derived localparam.
- NR, 2, number of read ports.
- NW, 1, number of write ports.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write to the read address is forwarded to rdata.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- re, in, NR, per-port read enable.
- ra, in, NR*AW, read addresses; port i uses ra[i*AW +: AW].
- rdata, out, NR*XLEN, registered read data; port i uses rdata[i*XLEN +: XLEN].
- we, in, NW, per-port write enable.
- wa, in, NW*AW, write addresses; port j uses wa[j*AW +: AW].
- wdata, in, NW*XLEN, write data; port j uses wdata[j*XLEN +: XLEN].

Behaviour:
- Reset:
  - rst_n=0 asynchronously clears every register and all rdata to 0, regardless of clk.
  - Writes and reads presented while rst_n=0 are discarded.
  - The first rising edge with rst_n=1 operates normally.
- Read:
  - Latency is 1 cycle. At posedge with re[i]=1, rdata[i] <= contents of ra[i], evaluated as described below.
  - With re[i]=0, rdata[i] holds its previous value.
- Read evaluation order, first match wins:
  - (a) ZERO_REG=1 and ra[i]=0: result is 0.
  - (b) ra[i] >= NREGS: result is 0.
  - (c) BYPASS=1 and some enabled write port targets ra[i] this edge: result is that port's wdata, using the write priority rule below.
  - (d) Otherwise: result is the register value before this edge.
- Write:
  - At posedge, for each j with we[j]=1, register wa[j] <= wdata[j].
  - Writes are dropped if wa[j] >= NREGS, or if ZERO_REG=1 and wa[j]=0.
- Write conflicts: when several enabled ports target the same address, the highest port index wins. This is deterministic and no error is flagged.
- BYPASS=0: a same-edge read of a register being written returns the old value (read-before-write).
- ZERO_REG=0: register 0 is an ordinary storage register.
- Storage size is (NREGS or NREGS-1) x XLEN flops. There is no internal state beyond storage and the rdata registers.
- Fully synchronous to clk apart from the reset.

Decomposition:
- Shared package regfile_pkg:
  - Default XLEN/NREGS constants.
  - ABI register index constants (REG_ZERO=0, REG_RA=1, REG_SP=2, ... REG_T6=31) for benches and decode.
  - A function computing AW.
- Sub-module register_file_rdport, instantiated NR times. It contains the address-range check, zero check, write-priority bypass mux, and rdata flop with enable and async clear.
- The top level holds storage and write decode.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, pulse rst_n low mid-cycle, then read x5 -> rdata=0 immediately on reset assertion and 0 after release.
- Basic read/write: write 0x12345678 to x10 at cycle N, read x10 at N+1 -> rdata=0x12345678 at N+2. Drop re -> rdata holds through an intervening write of 0x1 to x10.
- Bypass: BYPASS=1, same edge writes 0xA5A5A5A5 to x7 and reads x7 -> rdata=0xA5A5A5A5. Repeat with BYPASS=0 -> prior value returned.
- Zero register: write 0xFFFFFFFF to x0 -> subsequent read returns 0. Repeat with ZERO_REG=0 -> read returns 0xFFFFFFFF.
- Write conflict: NW=2, both ports write x3 (port0=0x111, port1=0x222) -> x3=0x222; a bypassed same-edge read also returns 0x222.
- Out-of-range: NREGS=24, write 0x55 to address 30 -> read of address 30 returns 0, and registers 0..23 are unchanged.
